// File: rtl/issue_queue.sv
// issue_queue: in-order issue buffer with a register scoreboard.
// Holds up to Depth decoded instructions and issues the head to its
// target functional unit once that unit is ready and the head has no
// RAW hazard (sources busy) or WAW hazard (destination busy).
// Writeback clears busy bits; flush empties queue and scoreboard.
//
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   flush                 drop all entries and pending bits
//   in_valid/in_ready     decode handshake (in_ready = !full)
//   in_rs1/in_rs2/in_rd   register operands, in_we = writes in_rd
//   in_fu, in_payload     target unit index, opaque payload
//   fu_ready              per-unit ready (combinational)
//   issue_valid           registered one-hot issue pulse
//   issue_rd/payload      registered head fields
//   wb_valid, wb_rd       writeback clearing a busy bit
//   count                 occupancy
//   stall_cycles          saturating head-blocked cycle count
module issue_queue #(
  parameter int Depth    = 4,
  parameter int NumRegs  = 32,
  parameter int NumFu    = 5,
  parameter int PayloadW = 64,
  localparam int RegW    = $clog2(NumRegs),
  localparam int FuW     = (NumFu > 1) ? $clog2(NumFu) : 1,
  localparam int CntW    = $clog2(Depth) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RegW-1:0]     in_rs1,
  input  logic [RegW-1:0]     in_rs2,
  input  logic [RegW-1:0]     in_rd,
  input  logic                in_we,
  input  logic [FuW-1:0]      in_fu,
  input  logic [PayloadW-1:0] in_payload,
  input  logic [NumFu-1:0]    fu_ready,
  output logic [NumFu-1:0]    issue_valid,
  output logic [RegW-1:0]     issue_rd,
  output logic [PayloadW-1:0] issue_payload,
  input  logic                wb_valid,
  input  logic [RegW-1:0]     wb_rd,
  output logic [CntW-1:0]     count,
  output logic [15:0]         stall_cycles
);

  localparam int AW = $clog2(Depth);
  // x0 is never tracked as busy
  localparam logic [NumRegs-1:0] X0_CLR = ~(NumRegs'(1));

  typedef struct packed {
    logic [RegW-1:0]     rs1;
    logic [RegW-1:0]     rs2;
    logic [RegW-1:0]     rd;
    logic                we;
    logic [FuW-1:0]      fu;
    logic [PayloadW-1:0] payload;
  } entry_t;

  entry_t              mem [Depth];
  entry_t              head;
  logic [CntW-1:0]     rd_ptr, wr_ptr;
  logic [NumRegs-1:0]  busy, wb_mask, eb, busy_set;
  logic [NumFu-1:0]    fu_sel;
  logic                empty, full, fu_ok, fire, enq;

  assign empty    = (rd_ptr == wr_ptr);
  assign full     = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign in_ready = !full;
  assign count    = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign enq      = in_valid && !full;

  // Writeback in the same cycle counts as already free (bypass).
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < NumRegs; i++)
      wb_mask[i] = wb_valid && (wb_rd == RegW'(i));
  end
  assign eb = busy & ~wb_mask;

  always_comb begin
    fu_sel = '0;
    for (int i = 0; i < NumFu; i++)
      fu_sel[i] = (head.fu == FuW'(i));
  end
  assign fu_ok = |(fu_sel & fu_ready);

  assign fire = !empty && !flush && fu_ok && !eb[head.rs1] && !eb[head.rs2]
                && !(head.we && eb[head.rd]);

  always_comb begin
    busy_set = '0;
    if (fire && head.we && (head.rd != '0))
      busy_set[head.rd] = 1'b1;
  end

  // Storage carries no reset; only slots between the pointers are read.
  always_ff @(posedge clock) begin
    if (!reset && !flush && enq)
      mem[wr_ptr[AW-1:0]] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, we: in_we,
                               fu: in_fu, payload: in_payload};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      busy          <= '0;
      issue_valid   <= '0;
      issue_rd      <= '0;
      issue_payload <= '0;
      stall_cycles  <= '0;
    end else if (flush) begin
      rd_ptr      <= wr_ptr;
      busy        <= '0;
      issue_valid <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + CntW'(1);
      if (fire) begin
        rd_ptr        <= rd_ptr + CntW'(1);
        issue_valid   <= fu_sel;
        issue_rd      <= head.rd;
        issue_payload <= head.payload;
      end else begin
        issue_valid <= '0;
      end
      // set from fire takes priority over a same-register writeback clear
      busy <= ((busy & ~wb_mask) | busy_set) & X0_CLR;
      if (!empty && !fire && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scoreboard bench for issue_queue. Expected issues are
// queued on acceptance and popped when issue_valid pulses; directed
// checks cover hazards, backpressure, flush, x0 and saturation.
module tb_issue_queue;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_we, wb_valid;
  logic [4:0]  in_rs1, in_rs2, in_rd, issue_rd, wb_rd;
  logic [2:0]  in_fu, count;
  logic [63:0] in_payload, issue_payload;
  logic [4:0]  fu_ready, issue_valid;
  logic [15:0] stall_cycles;

  issue_queue dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_we(in_we), .in_fu(in_fu), .in_payload(in_payload),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_payload(issue_payload), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .count(count), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          fu;
    logic [4:0]  rd;
    logic [63:0] payload;
    int          dcyc;
    int          lat;   // -1: latency not checked
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(negedge clock) begin
    if (!reset && issue_valid != '0) begin
      if (sb.size() == 0) chk("spurious_issue", 64'(issue_valid), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("issue_onehot", 64'(issue_valid), 64'd1 << mon_e.fu);
        chk("issue_rd", 64'(issue_rd), 64'(mon_e.rd));
        chk("issue_payload", issue_payload, mon_e.payload);
        if (mon_e.lat >= 0) chk("issue_latency", 64'(cyc - mon_e.dcyc), 64'(mon_e.lat));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = 1'b0; in_fu = '0; in_payload = '0;
    fu_ready = '0;
    tick(); tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Drive one op, wait (bounded) for in_ready, record expectation, accept.
  task automatic enq(input int fu, input int rs1, input int rs2, input int rd,
                     input bit we, input int lat);
    int k = 0;
    in_fu = 3'(fu); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_we = we;
    in_payload = {$urandom, $urandom};
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin tick(); k++; end
    if (k == 100) chk("enq_timeout", 64'd0, 64'd1);
    sb.push_back('{fu: fu, rd: 5'(rd), payload: in_payload, dcyc: cyc, lat: lat});
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int s0, mx;
    do_reset();
    // reset state
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_rd", 64'(issue_rd), 64'd0);
    chk("rst_issue_payload", issue_payload, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // back-to-back independent ALU ops
    fu_ready = '1; mx = 0;
    for (int i = 1; i <= 4; i++) begin
      enq(0, 0, 0, i, 1'b1, 2);
      @(negedge clock); if (count > mx) mx = count;
    end
    repeat (4) begin @(negedge clock); if (count > mx) mx = count; end
    chk("b2b_max_count", 64'(mx), 64'd1);
    chk("b2b_stall", 64'(stall_cycles), 64'd0);

    // RAW with writeback bypass
    do_reset(); fu_ready = '1;
    enq(2, 0, 0, 5, 1'b1, 2);
    enq(1, 5, 0, 6, 1'b1, -1);
    tick();
    s0 = stall_cycles;
    tick(); tick(); tick();
    chk("raw_stall_inc", 64'(stall_cycles - s0), 64'd3);
    chk("raw_held", 64'(issue_valid), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clock); chk("raw_not_yet", 64'(issue_valid), 64'd0);
    tick(); wb_valid = 1'b0;
    @(negedge clock); chk("raw_bypass_issue", 64'(issue_valid), 64'b00010);

    // WAW, non-writing op unaffected, set wins over same-cycle clear
    do_reset(); fu_ready = '1;
    enq(0, 0, 0, 7, 1'b1, 2);
    enq(3, 0, 0, 7, 1'b1, -1);
    tick(); tick(); tick();
    chk("waw_held", 64'(issue_valid), 64'd0);
    chk("waw_count", 64'(count), 64'd1);
    wb_valid = 1'b1; wb_rd = 5'd7;
    @(negedge clock); chk("waw_not_yet", 64'(issue_valid), 64'd0);
    tick(); wb_valid = 1'b0;
    @(negedge clock); chk("waw_issue", 64'(issue_valid), 64'b01000);
    enq(4, 0, 0, 7, 1'b0, 2);          // we=0 is not held by busy x7
    enq(0, 0, 0, 7, 1'b1, -1);         // x7 still busy from the second op
    tick(); tick(); tick();
    chk("waw_set_wins", 64'(count), 64'd1);
    wb_valid = 1'b1; wb_rd = 5'd7; tick(); wb_valid = 1'b0;
    tick(); tick();
    chk("waw_drained", 64'(count), 64'd0);

    // full queue and backpressure
    do_reset(); fu_ready = '0;
    for (int i = 0; i < 4; i++) enq(i, 0, 0, 10 + i, 1'b1, -1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_fu = 3'd4; in_rs1 = '0; in_rs2 = '0; in_rd = 5'd14; in_we = 1'b1;
    in_payload = {$urandom, $urandom}; in_valid = 1'b1;
    tick(); tick(); tick();
    chk("full_hold_count", 64'(count), 64'd4);
    fu_ready = '1;
    chk("full_no_passthru", 64'(in_ready), 64'd0);
    tick();
    chk("full_ready_after_drain", 64'(in_ready), 64'd1);
    sb.push_back('{fu: 4, rd: 5'd14, payload: in_payload, dcyc: cyc, lat: -1});
    tick(); in_valid = 1'b0;
    repeat (6) tick();
    chk("full_drained", 64'(count), 64'd0);

    // flush mid-operation
    do_reset(); fu_ready = '1;
    enq(0, 0, 0, 3, 1'b1, 2);
    tick(); tick();
    fu_ready = '0;
    for (int i = 0; i < 3; i++) enq(1, 0, 0, 0, 1'b0, -1);
    tick(); tick();
    chk("flush_pre_count", 64'(count), 64'd3);
    s0 = stall_cycles;
    flush = 1'b1; fu_ready = '1; in_valid = 1'b1; in_fu = 3'd2; in_rs1 = '0; in_we = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    chk("flush_stall_kept", 64'(stall_cycles), 64'(s0));
    enq(2, 3, 0, 8, 1'b1, 2);           // blocks forever if x3 stayed busy
    tick(); tick();

    // x0 handling
    do_reset(); fu_ready = '1;
    enq(1, 0, 0, 0, 1'b1, 2);
    enq(2, 0, 0, 0, 1'b1, 2);
    tick(); tick();
    chk("x0_no_stall", 64'(stall_cycles), 64'd0);

    // stall saturation
    fu_ready = '0;
    enq(3, 0, 0, 9, 1'b1, -1);
    repeat (70000) tick();
    chk("stall_saturate", 64'(stall_cycles), 64'hFFFF);
    flush = 1'b1; tick(); flush = 1'b0; sb.delete();
    tick();
    chk("stall_after_flush", 64'(stall_cycles), 64'hFFFF);

    begin
      int k = 0;
      while (sb.size() != 0 && k < 20) begin tick(); k++; end
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order issue buffer with an internal register scoreboard, placed between decode and the functional units of the OoO core. It holds up to `Depth` decoded instructions and issues the head to one of `NumFu` units when these conditions hold: the target unit is ready, both source registers are free of pending writes (RAW), and the destination has no pending write (WAW). Issue is a registered one-hot valid pulse. Writeback clears pending bits, and `flush` empties the queue and the scoreboard in one cycle.

## Interface
Parameters:
- `Depth`, default 4: queue entries; power of two, at least 2.
- `NumRegs`, default 32: architectural registers; `RegW = $clog2(NumRegs)`.
- `NumFu`, default 5: functional units; `FuW = $clog2(NumFu)`.
- `PayloadW`, default 64: opaque per-instruction payload width.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: drops all queued entries and pending bits.
- `in_valid`, in, 1: decode offers an instruction.
- `in_ready`, out, 1: equals `!full`.
- `in_rs1`, `in_rs2`, in, RegW each: source registers.
- `in_rd`, in, RegW: destination register.
- `in_we`, in, 1: instruction writes `in_rd`.
- `in_fu`, in, FuW: target unit index; must be `< NumFu`.
- `in_payload`, in, PayloadW: carried through unchanged.
- `fu_ready`, in, NumFu: per-unit ready, sampled combinationally.
- `issue_valid`, out, NumFu: registered one-hot issue pulse.
- `issue_rd`, out, RegW: registered head `rd`.
- `issue_payload`, out, PayloadW: registered head payload.
- `wb_valid`, in, 1: writeback completing.
- `wb_rd`, in, RegW: register being written back.
- `count`, out, `$clog2(Depth)+1`: current occupancy.
- `stall_cycles`, out, 16: saturating count of head-blocked cycles.

## Operation
- Circular FIFO with `rd_ptr`/`wr_ptr` of `$clog2(Depth)+1` bits. Full means the pointer MSBs differ and the low bits are equal; empty means the pointers are equal.
- Enqueue occurs when `in_valid && in_ready`. There is no pass-through: while full, `in_ready` stays 0 even if a dequeue happens in the same cycle.
- Scoreboard is a `busy[NumRegs]` bit vector; `busy[0]` is hard-wired to 0.
- Effective busy: `eb(r) = busy[r] && !(wb_valid && wb_rd == r)`, i.e. same-cycle writeback bypass.
- Head `fire` condition: `!empty && !flush && fu_ready[head.fu] && !eb(head.rs1) && !eb(head.rs2) && !(head.we && eb(head.rd))`.
- On `fire`:
  - `rd_ptr` increments.
  - `issue_valid` next cycle is `1 << head.fu`; `issue_rd` and `issue_payload` load from the head.
  - If `head.we` and `head.rd != 0`, `busy[head.rd]` is set.
- Without `fire`, `issue_valid` next cycle is 0; `issue_rd` and `issue_payload` hold their values.
- On `wb_valid`, `busy[wb_rd]` clears. If the same register is both set by `fire` and cleared by writeback in one cycle, set wins.
- Stall counting: a cycle counts as blocked when `!empty && !fire && !flush`. On such cycles `stall_cycles` increments, saturating at 0xFFFF.
- Flush:
  - Pointers are equalised (queue empties) and all `busy` bits clear.
  - `issue_valid` next cycle is 0, and the in-cycle enqueue is dropped.
  - `stall_cycles` is kept.
- Writebacks arriving after a flush clear already-clear bits, which is harmless.
- Strict in-order issue: a blocked head blocks every younger entry.

## Timing
- Reset values: `issue_valid = 0`, `issue_rd = 0`, `issue_payload = 0`, `count = 0`, `stall_cycles = 0`, `in_ready = 1`, all `busy` bits 0, pointers 0.
- Latency into an empty queue: `in_valid` accepted at edge N, the entry is at the head in cycle N+1 and may fire then, so `issue_valid` is asserted in cycle N+2. Minimum latency is 2 cycles.
- Sustained throughput is 1 issue per cycle.
- `issue_valid` is a single-cycle pulse per instruction; units latch on it and need no acknowledgement.
- `fu_ready` must be 1 in the fire cycle.
- A dependent instruction can fire in the same cycle as the producer's `wb_valid`, via the bypass.
- `count` and `in_ready` are registered-state derived; no combinational path from `in_valid` exists.
- Reset or flush asserted mid-operation takes effect at the next edge; no issue pulse appears in the following cycle.

## Test plan
- **Back-to-back independent issue:** enqueue 4 ALU ops (fu=0, rd=1..4, rs=0) with `fu_ready` all 1. Expect `issue_valid = 5'b00001` in cycles 2–5, `count` peaking at 1, and `stall_cycles = 0`.
- **RAW with bypass:** op A writes x5 (fu=2), op B reads rs1=x5. Expect B held and `stall_cycles` incrementing. Drive `wb_valid`, `wb_rd = 5` in cycle K; expect B's `issue_valid` in cycle K+1.
- **WAW:** two ops both writing x7. The second is held until `wb_rd = 7`. A non-writing op (`we = 0`) with rd=7 is not held.
- **Full queue and backpressure:** `fu_ready = 0`, enqueue 5 ops. Expect `in_ready = 0` after 4 accepted and `count = 4`; the 5th op is accepted only after `fu_ready` rises and one entry drains.
- **Flush mid-operation:** 3 entries queued, x3 busy; assert `flush`. Next cycle: `count = 0`, `issue_valid = 0`, `busy[3] = 0`, and a new op reading x3 issues 2 cycles after enqueue.
- **x0 handling and saturation:** an op writing x0 never sets busy, and a following reader of x0 issues without stall. Force 70000 blocked cycles; expect `stall_cycles = 0xFFFF`.
